// File: rtl/wb_mgr_pkg.sv
// wb_mgr_pkg: shared state encoding and default configuration for wishbone_manager.
package wb_mgr_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE, RELEASE} state_t;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam logic [31:0] ERR_DATA_DEF = 32'hBAD0_BAD0;
endpackage

// File: rtl/wishbone_manager_if.sv
// wishbone_manager_if: classic Wishbone B4 manager-to-subordinate signal bundle.
interface wishbone_manager_if
    import wb_mgr_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic [ADDR_W-1:0]   ADR_O;
    logic [DATA_W-1:0]   DAT_O;
    logic [DATA_W/8-1:0] SEL_O;
    logic                WE_O;
    logic                STB_O;
    logic                CYC_O;
    logic [DATA_W-1:0]   DAT_I;
    logic                ACK_I;
    modport master (output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O, input DAT_I, ACK_I);
    modport slave (input ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O, output DAT_I, ACK_I);
endinterface

// File: rtl/wishbone_manager.sv
// wishbone_manager: runs one classic Wishbone cycle per CPU read/write request.
// Define WB_TIMEOUT_EN to abort a cycle that sees no ACK within TIMEOUT_CYCLES.
module wishbone_manager
    import wb_mgr_pkg::*;
#(
    parameter int                ADDR_W         = ADDR_W_DEF,
    parameter int                DATA_W         = DATA_W_DEF,
    parameter int                TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEF
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic                read_i,
    input  logic                write_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [ADDR_W-1:0]   adr_i,
    input  logic [DATA_W-1:0]   cpu_dat_i,
    output logic                busy_o,
    output logic [DATA_W-1:0]   cpu_dat_o,
    output logic                bus_err,
    wishbone_manager_if.master  wb
);
    state_t              state;
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W-1:0]   dat;
    logic [DATA_W/8-1:0] sel;
    logic                we;
    logic                cyc;
    logic [DATA_W-1:0]   rdat;
`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic             err;
    assign bus_err = err;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, ERR_DATA};
    assign bus_err = 1'b0;
`endif

    // busy is combinational in IDLE so the requester sees it in the request cycle
    assign busy_o    = state == IDLE ? (read_i | write_i) : state != RELEASE;
    assign cpu_dat_o = rdat;
    assign wb.ADR_O  = adr;
    assign wb.DAT_O  = dat;
    assign wb.SEL_O  = sel;
    assign wb.WE_O   = we;
    assign wb.STB_O  = cyc;
    assign wb.CYC_O  = cyc;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            adr   <= '0;
            dat   <= '0;
            sel   <= '0;
            we    <= 1'b0;
            cyc   <= 1'b0;
            rdat  <= '0;
`ifdef WB_TIMEOUT_EN
            cnt   <= '0;
            err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (read_i | write_i) begin
                    adr   <= adr_i;
                    dat   <= cpu_dat_i;
                    sel   <= sel_i;
                    we    <= write_i & ~read_i;
                    cyc   <= 1'b1;
                    state <= REQ;
`ifdef WB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                REQ: begin
                    if (wb.ACK_I) begin
                        if (!we) rdat <= wb.DAT_I;
                        cyc   <= 1'b0;
                        state <= DONE;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        if (!we) rdat <= ERR_DATA;
                        cyc   <= 1'b0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else
                        cnt <= cnt + 1'b1;
`endif
                end
                DONE: begin
                    state <= RELEASE;
`ifdef WB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                RELEASE: if (!(read_i | write_i)) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wishbone_manager.sv
// tb_wishbone_manager: directed checks of wishbone_manager handshake, latency and reset.
module tb_wishbone_manager;
`ifdef WB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif
    logic        clk = 0;
    logic        nRST = 0;
    logic        read_i = 0, write_i = 0;
    logic [3:0]  sel_i = 0;
    logic [31:0] adr_i = 0, cpu_dat_i = 0;
    logic        busy_o, bus_err;
    logic [31:0] cpu_dat_o;
    int          errors = 0, checks = 0;

    wishbone_manager_if #(.ADDR_W(32), .DATA_W(32)) wb ();

    wishbone_manager #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hBAD0_BAD0)) dut (
        .clk(clk), .nRST(nRST), .read_i(read_i), .write_i(write_i), .sel_i(sel_i),
        .adr_i(adr_i), .cpu_dat_i(cpu_dat_i), .busy_o(busy_o), .cpu_dat_o(cpu_dat_o),
        .bus_err(bus_err), .wb(wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        wb.ACK_I = 0;
        wb.DAT_I = 0;
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_cyc", wb.CYC_O, 0);
        chk("rst_stb", wb.STB_O, 0);
        chk("rst_dat", cpu_dat_o, 0);
        chk("rst_err", bus_err, 0);
        nRST = 1;
        step();
        // 1: zero-wait read
        read_i = 1; adr_i = 32'h0000_1000;
        #1 chk("t1_busy_idle", busy_o, 1);
        chk("t1_stb_idle", wb.STB_O, 0);
        step();
        chk("t1_stb", wb.STB_O, 1);
        chk("t1_cyc", wb.CYC_O, 1);
        chk("t1_adr", wb.ADR_O, 32'h0000_1000);
        chk("t1_we", wb.WE_O, 0);
        wb.ACK_I = 1; wb.DAT_I = 32'h1234_5678;
        step();
        wb.ACK_I = 0; wb.DAT_I = 0;
        chk("t1_stb_done", wb.STB_O, 0);
        chk("t1_busy_done", busy_o, 1);
        chk("t1_dat", cpu_dat_o, 32'h1234_5678);
        step();
        chk("t1_busy_rel", busy_o, 0);
        read_i = 0;
        step();
        chk("t1_busy_idle2", busy_o, 0);
        // 2: write with three wait states, inputs changed after acceptance
        write_i = 1; adr_i = 32'h2000; cpu_dat_i = 32'hCAFE_F00D; sel_i = 4'hF;
        step();
        adr_i = 32'hFFFF_0000; cpu_dat_i = 32'h0; sel_i = 4'h1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stb", wb.STB_O, 1);
            chk("t2_we", wb.WE_O, 1);
            chk("t2_dato", wb.DAT_O, 32'hCAFE_F00D);
            chk("t2_adr", wb.ADR_O, 32'h2000);
            chk("t2_sel", wb.SEL_O, 4'hF);
            if (i == 3) begin
                wb.ACK_I = 1; wb.DAT_I = 32'hDEAD_BEEF;
            end
            step();
        end
        wb.ACK_I = 0;
        chk("t2_stb_done", wb.STB_O, 0);
        chk("t2_busy_done", busy_o, 1);
        chk("t2_dat_hold", cpu_dat_o, 32'h1234_5678);
        step();
        chk("t2_busy_rel", busy_o, 0);
        write_i = 0;
        step();
        // 3: request held after completion must not re-issue
        read_i = 1; adr_i = 32'h3000;
        step();
        chk("t3_stb", wb.STB_O, 1);
        wb.ACK_I = 1; wb.DAT_I = 32'hAAAA_5555;
        step();
        wb.ACK_I = 0;
        chk("t3_dat", cpu_dat_o, 32'hAAAA_5555);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_held_busy", busy_o, 0);
            chk("t3_held_stb", wb.STB_O, 0);
            step();
        end
        read_i = 0;
        step();
        chk("t3_idle_stb", wb.STB_O, 0);
        read_i = 1; adr_i = 32'h3004;
        step();
        chk("t3_stb2", wb.STB_O, 1);
        chk("t3_adr2", wb.ADR_O, 32'h3004);
        wb.ACK_I = 1; wb.DAT_I = 32'h0BAD_F00D;
        step();
        wb.ACK_I = 0;
        step();
        read_i = 0;
        step();
        // 4: simultaneous read and write, read wins
        read_i = 1; write_i = 1; adr_i = 32'h4000; cpu_dat_i = 32'h1111_1111;
        step();
        chk("t4_we", wb.WE_O, 0);
        chk("t4_stb", wb.STB_O, 1);
        wb.ACK_I = 1; wb.DAT_I = 32'h8765_4321;
        step();
        wb.ACK_I = 0;
        chk("t4_dat", cpu_dat_o, 32'h8765_4321);
        step();
        read_i = 0; write_i = 0;
        step();
        // 5: asynchronous reset during REQ
        read_i = 1; adr_i = 32'h5000;
        step();
        chk("t5_stb", wb.STB_O, 1);
        #2 nRST = 0; read_i = 0;
        #1 chk("t5_cyc", wb.CYC_O, 0);
        chk("t5_stb_rst", wb.STB_O, 0);
        chk("t5_busy", busy_o, 0);
        chk("t5_dat", cpu_dat_o, 0);
        chk("t5_err", bus_err, 0);
        step();
        nRST = 1;
        step();
`ifdef WB_TIMEOUT_EN
        // 6: timeout abort on a read with no ACK
        read_i = 1; adr_i = 32'h6000;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t6_stb", wb.STB_O, 1);
            chk("t6_err_req", bus_err, 0);
            step();
        end
        chk("t6_stb_drop", wb.STB_O, 0);
        chk("t6_err", bus_err, 1);
        chk("t6_dat", cpu_dat_o, 32'hBAD0_BAD0);
        chk("t6_busy_done", busy_o, 1);
        step();
        chk("t6_err_clr", bus_err, 0);
        chk("t6_busy_rel", busy_o, 0);
        read_i = 0;
        step();
`else
        // without timeout a REQ waits indefinitely
        read_i = 1; adr_i = 32'h6000;
        step();
        for (int i = 0; i < 300; i++) step();
        chk("t6_stb_wait", wb.STB_O, 1);
        chk("t6_err_tied", bus_err, 0);
        wb.ACK_I = 1; wb.DAT_I = 32'h5A5A_A5A5;
        step();
        wb.ACK_I = 0;
        chk("t6_dat_late", cpu_dat_o, 32'h5A5A_A5A5);
        read_i = 0;
        step();
        step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
